mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of all ports.
REQ-002 Parameter: MAX_CONSEC, 4, max consecutive MEM grants while IF waits.
REQ-003 The block SHALL use one clock and a synchronous active-high reset: clka (in, 1, rising-edge clock), then rst (in, 1, sync active-high reset).
REQ-004 Ports:
if_req in 1: fetch request, held until if_valid.
if_addr in AW: fetch byte address.
if_flush in 1: discard the outstanding fetch.
if_rdata out 32: fetched word.
if_valid out 1: if_rdata valid this cycle.
if_stall out 1: fetch pending, not yet served.
mem_req in 1: load/store request, held until done.
mem_we in 1: 1 = store.
mem_wstrb in 4: store byte enables.
mem_addr in AW: data byte address.
mem_wdata in 32: store data.
mem_rdata out 32: load data.
mem_valid out 1: load data valid, or store accepted.
mem_stall out 1: data access pending.
ram_en out 1: RAM access strobe.
ram_we out 4: RAM byte write enables.
ram_addr out AW: RAM address.
ram_wdata out 32: RAM write data.
ram_rdata in 32: RAM read data, 1-cycle latency.

Function
REQ-005 The FSM SHALL have states IDLE, RD_IF and RD_MEM; grants SHALL be issued only in IDLE.
REQ-006 In IDLE with a winner, the block SHALL drive the ram_* outputs combinationally from the winner's fields in the same cycle, with ram_en=1.
REQ-007 Arbitration: MEM SHALL win over IF, except when starve_cnt==MAX_CONSEC and if_req=1, in which case IF SHALL win.
REQ-008 starve_cnt SHALL increment, saturating at MAX_CONSEC, on each MEM grant while if_req=1; it SHALL clear on an IF grant or whenever if_req=0.
REQ-009 A granted read SHALL move the FSM to RD_x. In RD_x, x_valid=1 and x_rdata=ram_rdata, and the FSM SHALL return to IDLE with no grant issued in that cycle (2 cycles per read).
REQ-010 A store SHALL complete in its grant cycle: ram_we=mem_wstrb, mem_valid=1, and the FSM SHALL stay IDLE. A store with mem_wstrb=0 SHALL still be granted and acknowledged.
REQ-011 An IF read SHALL drive ram_we=0.
REQ-012 Stalls: x_stall = x_req & ~x_valid in every cycle.
REQ-013 if_flush in IDLE SHALL suppress the IF grant that cycle.
REQ-014 if_flush in RD_IF SHALL force if_valid=0 while the FSM still returns to IDLE.
REQ-015 if_flush SHALL NOT affect MEM.
REQ-016 Outputs SHALL be zero when idle: ram_en=0, ram_we=0, x_valid=0; x_rdata holds its last value.
REQ-017 When both requests arrive in the same cycle with starve_cnt<MAX_CONSEC, MEM SHALL be served first and IF granted in the next IDLE cycle.
REQ-018 Address bits SHALL pass through unmodified; alignment is the requester's responsibility.

Reset
REQ-019 While rst=1 the block SHALL force state=IDLE, starve_cnt=0, if_valid=0, mem_valid=0, ram_en=0, ram_we=0, if_rdata=0 and mem_rdata=0.
REQ-020 Reset asserted in RD_x SHALL discard the in-flight read; no valid SHALL be asserted after reset releases.
REQ-021 The first grant SHALL be possible in the first cycle with rst=0.

Structure
REQ-022 Shared package mem_arb_pkg SHALL hold the state enum (IDLE, RD_IF, RD_MEM) and the MAX_CONSEC default.
REQ-023 The priority and starvation counter SHALL be one sub-module, mem_arb_prio (inputs if_req, mem_req, grant strobe; output winner).

Verification
REQ-024 Single fetch: if_req=1, if_addr=0x0, ram_rdata=0x20020005 in the following cycle -> ram_en=1 in cycle 0; if_valid=1 and if_rdata=0x20020005 in cycle 1; if_stall=1 in cycle 0 only.
REQ-025 Store: mem_we=1, mem_addr=84, mem_wdata=7, mem_wstrb=0xF -> in the same cycle ram_we=0xF, ram_addr=84, ram_wdata=7, mem_valid=1, mem_stall=0.
REQ-026 Collision: if_req and mem_req (load) rise together -> MEM read served in cycles 0–1, IF read in cycles 2–3.
REQ-027 Starvation: mem_req held with back-to-back stores while if_req=1 -> IF granted on the 5th arbitration cycle, after 4 MEM grants; starve_cnt then reads 0.
REQ-028 Flush: if_flush=1 during RD_IF -> if_valid stays 0, next grant in the following cycle.
REQ-029 Reset mid-read: rst=1 in RD_MEM -> mem_valid=0 and ram_en=0 the next cycle; after release, a new load completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
package mem_arb_pkg;

  localparam int MAX_CONSEC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_IF   = 2'd1,
    WIN_MEM  = 2'd2
  } winner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed MEM-over-IF priority with a saturating starvation counter that
// hands the port to IF after MAX_CONSEC back-to-back MEM grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_CONSEC = MAX_CONSEC_DEF
) (
  input  logic    clka,
  input  logic    rst,
  input  logic    if_req,
  input  logic    mem_req,
  input  logic    grant,
  output winner_t winner
);

  localparam int            CW      = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

  logic [CW-1:0] starve_cnt;

  always_comb begin
    winner = WIN_NONE;
    if (if_req && (starve_cnt == CNT_MAX)) begin
      winner = WIN_IF;
    end else if (mem_req) begin
      winner = WIN_MEM;
    end else if (if_req) begin
      winner = WIN_IF;
    end
  end

  // Only a MEM grant that actually makes IF wait counts toward starvation.
  always_ff @(posedge clka) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (grant) begin
      if (winner == WIN_IF) begin
        starve_cnt <= '0;
      end else if ((winner == WIN_MEM) && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch, load/store) arbiter for a single-port
// RAM with 1-cycle read latency. Grants happen only in IDLE.
//
// state  | meaning
// IDLE   | arbitrate; drive ram_* for the winner in the same cycle
// RD_IF  | fetch data returning from RAM, present on if_rdata
// RD_MEM | load data returning from RAM, present on mem_rdata
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int MAX_CONSEC = MAX_CONSEC_DEF
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [3:0]    mem_wstrb,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic [31:0]   mem_rdata,
  output logic          mem_valid,
  output logic          mem_stall,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  arb_state_t  state;
  winner_t     winner;
  logic        if_req_arb;
  logic        grant;
  logic        grant_if;
  logic        grant_mem;
  logic        store_go;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;

  // A flushed fetch must not win this cycle, but MEM is unaffected.
  assign if_req_arb = if_req & ~if_flush;

  mem_arb_prio #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_prio (
    .clka    (clka),
    .rst     (rst),
    .if_req  (if_req_arb),
    .mem_req (mem_req),
    .grant   (grant),
    .winner  (winner)
  );

  assign grant     = !rst && (state == IDLE) && (winner != WIN_NONE);
  assign grant_if  = grant && (winner == WIN_IF);
  assign grant_mem = grant && (winner == WIN_MEM);
  assign store_go  = grant_mem && mem_we;

  always_comb begin
    ram_en    = grant;
    ram_we    = 4'h0;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (grant_mem) begin
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
      if (mem_we) begin
        ram_we = mem_wstrb;
      end
    end else if (grant_if) begin
      ram_addr = if_addr;
    end
  end

  assign if_valid  = !rst && (state == RD_IF) && !if_flush;
  assign mem_valid = !rst && ((state == RD_MEM) || store_go);

  // Read data is forwarded live from the RAM and captured so it holds afterwards.
  assign if_rdata  = rst ? 32'h0 : (if_valid ? ram_rdata : if_rdata_q);
  assign mem_rdata = rst ? 32'h0 : ((state == RD_MEM) ? ram_rdata : mem_rdata_q);

  assign if_stall  = if_req & ~if_valid;
  assign mem_stall = mem_req & ~mem_valid;

  always_ff @(posedge clka) begin
    if (rst) begin
      state       <= IDLE;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            state <= RD_IF;
          end else if (grant_mem && !mem_we) begin
            state <= RD_MEM;
          end
        end
        RD_IF: begin
          if (!if_flush) begin
            if_rdata_q <= ram_rdata;
          end
          state <= IDLE;
        end
        RD_MEM: begin
          mem_rdata_q <= ram_rdata;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int MAXC = 4;

  logic          clka = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [31:0]   if_rdata;
  logic          if_valid;
  logic          if_stall;
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_valid;
  logic          mem_stall;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_if_valid  = 1'b0;
  logic exp_mem_valid = 1'b0;

  mem_arbiter #(
    .AW         (AW),
    .MAX_CONSEC (MAXC)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .mem_stall (mem_stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'h20020005 : ((32'h9E3779B9 * 32'(i)) ^ 32'h00C0FFEE);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // 256-word byte-writable RAM, read data one cycle after the strobe.
  initial begin : ram_model
    logic [31:0] ram_mem [256];
    logic [31:0] w;
    logic [31:0] rd;
    for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
    forever begin
      @(posedge clka);
      if (ram_en) begin
        rd = ram_mem[ram_addr[9:2]];
        w  = rd;
        for (int b = 0; b < 4; b++) if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
        ram_mem[ram_addr[9:2]] = w;
        ram_rdata <= rd;
      end
    end
  end

  // Reference model: who owns the port, how long IF has waited, and what
  // each word of memory should contain after the stores seen so far.
  initial begin : scoreboard
    logic [31:0]   shadow [256];
    int            busy;
    int            starve;
    int            win;
    logic [31:0]   if_hold, mem_hold;
    logic [AW-1:0] rd_addr;
    logic          e_en, e_ifv, e_memv, e_store, ife;
    logic [3:0]    e_we;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_ifd, e_memd, w;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    busy = 0; starve = 0; if_hold = 0; mem_hold = 0; rd_addr = '0;
    forever begin
      @(negedge clka);
      e_en = 0; e_ifv = 0; e_memv = 0; e_store = 0; e_we = 4'h0;
      e_addr = '0; e_wdata = 32'h0;
      if (rst) begin
        busy = 0; starve = 0; if_hold = 0; mem_hold = 0;
      end else begin
        ife = if_req & ~if_flush;
        if (busy == 1) begin
          if (!if_flush) begin
            e_ifv   = 1;
            if_hold = shadow[rd_addr[9:2]];
          end
          busy = 0;
        end else if (busy == 2) begin
          e_memv   = 1;
          mem_hold = shadow[rd_addr[9:2]];
          busy     = 0;
        end else begin
          win = 0;
          if (ife && starve == MAXC) win = 1;
          else if (mem_req)          win = 2;
          else if (ife)              win = 1;
          if (win == 1) begin
            e_en = 1; e_addr = if_addr; busy = 1; rd_addr = if_addr;
            starve = 0;
          end else if (win == 2) begin
            e_en = 1; e_addr = mem_addr;
            if (mem_we) begin
              e_we = mem_wstrb; e_wdata = mem_wdata; e_memv = 1; e_store = 1;
            end else begin
              busy = 2; rd_addr = mem_addr;
            end
            if (ife && starve < MAXC) starve++;
          end
        end
        if (!ife) starve = 0;
      end
      e_ifd  = if_hold;
      e_memd = mem_hold;
      chk("ram_en", ram_en, e_en);
      chk("ram_we", ram_we, e_we);
      if (e_en)    chk("ram_addr", ram_addr, e_addr);
      if (e_store) chk("ram_wdata", ram_wdata, e_wdata);
      chk("if_valid", if_valid, e_ifv);
      chk("mem_valid", mem_valid, e_memv);
      chk("if_stall", if_stall, if_req & ~e_ifv);
      chk("mem_stall", mem_stall, mem_req & ~e_memv);
      chk("if_rdata", if_rdata, e_ifd);
      chk("mem_rdata", mem_rdata, e_memd);
      if (e_store) begin
        w = shadow[e_addr[9:2]];
        for (int b = 0; b < 4; b++) if (e_we[b]) w[8*b +: 8] = e_wdata[8*b +: 8];
        shadow[e_addr[9:2]] = w;
      end
      exp_if_valid  = e_ifv;
      exp_mem_valid = e_memv;
    end
  end

  initial begin : stimulus
    rst = 1; if_req = 1; if_addr = '0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_wstrb = 4'h0; mem_addr = '0; mem_wdata = 32'h0;

    tick(); tick(); #2;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_stall", if_stall, 1);

    // single fetch, granted in the first cycle out of reset
    tick(); rst = 0; #2;
    chk("f0_ram_en", ram_en, 1);
    chk("f0_ram_addr", ram_addr, 0);
    chk("f0_ram_we", ram_we, 0);
    chk("f0_if_stall", if_stall, 1);
    tick(); #2;
    chk("f1_if_valid", if_valid, 1);
    chk("f1_if_rdata", if_rdata, 32'h20020005);
    chk("f1_if_stall", if_stall, 0);
    chk("f1_ram_en", ram_en, 0);
    tick(); if_req = 0; #2;
    chk("f2_if_valid", if_valid, 0);
    chk("f2_if_rdata_hold", if_rdata, 32'h20020005);

    // store
    tick(); mem_req = 1; mem_we = 1; mem_addr = 84; mem_wdata = 7; mem_wstrb = 4'hF; #2;
    chk("s_ram_we", ram_we, 4'hF);
    chk("s_ram_addr", ram_addr, 84);
    chk("s_ram_wdata", ram_wdata, 7);
    chk("s_mem_valid", mem_valid, 1);
    chk("s_mem_stall", mem_stall, 0);

    // collision: load and fetch together
    tick(); mem_we = 0; mem_wstrb = 4'h0; if_req = 1; if_addr = 0; #2;
    chk("c0_ram_addr", ram_addr, 84);
    chk("c0_ram_we", ram_we, 0);
    chk("c0_if_stall", if_stall, 1);
    chk("c0_mem_stall", mem_stall, 1);
    tick(); #2;
    chk("c1_mem_valid", mem_valid, 1);
    chk("c1_mem_rdata", mem_rdata, 7);
    chk("c1_if_valid", if_valid, 0);
    tick(); mem_req = 0; #2;
    chk("c2_ram_en", ram_en, 1);
    chk("c2_ram_addr", ram_addr, 0);
    tick(); #2;
    chk("c3_if_valid", if_valid, 1);
    chk("c3_if_rdata", if_rdata, 32'h20020005);

    // starvation: back-to-back stores while IF waits
    mem_req = 1; mem_we = 1; mem_wstrb = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      mem_addr  = 32'h100 + 32'(4 * k);
      mem_wdata = 32'hA0 + 32'(k);
      if (k == 0) if_addr = 4;
      if (k == 6) if_addr = 8;
      #2;
      if (k == 4 || k == 10) begin
        chk("st_if_grant_addr", ram_addr, (k == 4) ? 32'd4 : 32'd8);
        chk("st_if_grant_nomem", mem_valid, 0);
      end else if (k == 5 || k == 11) begin
        chk("st_if_valid", if_valid, 1);
        chk("st_mem_wait", mem_stall, 1);
      end else begin
        chk("st_mem_grant_addr", ram_addr, 32'h100 + 32'(4 * k));
        chk("st_mem_valid", mem_valid, 1);
      end
    end

    // flush during RD_IF
    tick(); mem_req = 0; if_addr = 12; #2;
    chk("fl0_ram_en", ram_en, 1);
    tick(); if_flush = 1; mem_req = 1; mem_we = 0; mem_wstrb = 4'h0; mem_addr = 84; #2;
    chk("fl1_if_valid", if_valid, 0);
    chk("fl1_if_stall", if_stall, 1);
    tick(); if_flush = 0; if_req = 0; #2;
    chk("fl2_ram_en", ram_en, 1);
    chk("fl2_ram_addr", ram_addr, 84);
    tick(); #2;
    chk("fl3_mem_valid", mem_valid, 1);
    chk("fl3_mem_rdata", mem_rdata, 7);

    // reset in the middle of a load
    tick(); #2;
    chk("r0_ram_en", ram_en, 1);
    tick(); rst = 1; #2;
    chk("r1_mem_valid", mem_valid, 0);
    chk("r1_ram_en", ram_en, 0);
    tick(); #2;
    chk("r2_mem_valid", mem_valid, 0);
    chk("r2_ram_en", ram_en, 0);
    chk("r2_mem_rdata", mem_rdata, 0);
    tick(); rst = 0; #2;
    chk("r3_ram_en", ram_en, 1);
    chk("r3_mem_valid", mem_valid, 0);
    tick(); #2;
    chk("r4_mem_valid", mem_valid, 1);
    chk("r4_mem_rdata", mem_rdata, 7);
    tick(); mem_req = 0;

    // randomized traffic; requesters hold until their valid (or a flush)
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 79) == 0);
      if (!if_req || exp_if_valid || if_flush) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if_flush = if_req && ($urandom_range(0, 11) == 0);
      if (!mem_req || exp_mem_valid) begin
        mem_req   = $urandom_range(0, 1) == 1;
        mem_we    = $urandom_range(0, 1) == 1;
        mem_wstrb = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
      end
    end

    tick(); rst = 0; if_req = 0; mem_req = 0; if_flush = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
